fp_std_sched: RTL and testbench
===============================

FP_STD_SCHED -- requirements
Module: fp_std_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 24, giving the float operand/result width (sign[23], exp[22:15], mant[14:0]).
REQ-002 SHALL have parameter NREQ, default 4, giving the number of requesters sharing one fp_std unit (2..8).
REQ-003 SHALL have port core_clock_i, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port core_reset_ni, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid_i, input, NREQ, per-requester operation valid.
REQ-006 SHALL have port req_ready_o, output, NREQ, per-requester accept (one-hot or zero).
REQ-007 SHALL have port req_a_i, input, NREQ*WIDTH, operand A; requester i at [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_b_i, input, NREQ*WIDTH, operand B; same packing.
REQ-009 SHALL have port req_op_i, input, NREQ*3, op code: 0 add/sub, 1 max, 2 min, 3..7 illegal.
REQ-010 SHALL have port rsp_valid_o, output, 1, result valid.
REQ-011 SHALL have port rsp_ready_i, input, 1, consumer accept.
REQ-012 SHALL have port rsp_data_o, output, WIDTH, result.
REQ-013 SHALL have port rsp_id_o, output, $clog2(NREQ), index of the originating requester.
REQ-014 SHALL have port rsp_err_o, output, 1, set when the op was illegal.
REQ-015 SHALL have port busy_o, output, 1, high when either pipeline stage holds valid data.

Function
REQ-016 SHALL instantiate exactly one fp_std (WIDTH) shared by all requesters; the unit is combinational.
REQ-017 SHALL implement a 2-stage pipeline: S1 holds {a, b, op, id, err}, fed to fp_std; S2 holds {result, id, err}, driving rsp_*.
REQ-018 SHALL accept requester i in cycle C iff req_valid_i[i] & req_ready_o[i]; rsp_valid_o first asserts in cycle C+2 (latency 2, no stall).
REQ-019 SHALL compute the S2 advance: S2 loads when S2 empty or (rsp_valid_o & rsp_ready_i).
REQ-020 SHALL compute the S1 advance: S1 accepts a new request when S1 empty or S1 moves to S2 in the same cycle.
REQ-021 SHALL make req_ready_o combinational from req_valid_i, the round-robin pointer and REQ-020; at most one bit is set, and it is never set for an invalid requester.
REQ-022 SHALL use round-robin priority: the search starts at pointer p and wraps modulo NREQ; on a grant to i, p <= (i+1) mod NREQ; with no grant, p holds.
REQ-023 SHALL sustain one accept per cycle with the consumer ready continuously (full throughput).
REQ-024 SHALL, for op 3..7, present op to fp_std unchanged (result 0) and set err in S1/S2.
REQ-025 SHALL keep rsp_data_o, rsp_id_o and rsp_err_o stable while rsp_valid_o & !rsp_ready_i.
REQ-026 SHALL capture operands only on accept; requesters may change operands freely while not granted.
REQ-027 SHALL, with both stages full and rsp_ready_i low, drive req_ready_o to 0; when rsp_ready_i rises, S2 drains, S1 moves and a new grant occurs in the same cycle.
REQ-028 SHALL, with S1 empty and S2 full/stalled, still accept one request into S1.
REQ-029 SHALL keep the id field width at max(1, $clog2(NREQ)).

Reset
REQ-030 SHALL, on core_reset_ni low, immediately clear the S1/S2 valid bits, set p=0 and drive rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0, busy_o=0, req_ready_o=0.
REQ-031 SHALL discard in-flight operations when reset asserts mid-operation; no response for them appears after release.
REQ-032 SHALL allow the first accept in the first cycle after core_reset_ni deasserts.

Verification
REQ-033 SHALL cover: requester 0 only, a=0x3F8000 (1.0), b=0x3F8000, op=0, rsp_ready_i=1 -> rsp_valid_o 2 cycles later, data 0x400000, id 0, err 0.
REQ-034 SHALL cover: all 4 requesters valid continuously, consumer always ready -> grants in order 0,1,2,3,0,..., one response per cycle, ids in the same order.
REQ-035 SHALL cover: requester 2, a=0x3F8000, b=0x400000, op=1 then op=2 -> results 0x400000 then 0x3F8000, id 2.
REQ-036 SHALL cover: rsp_ready_i low for 5 cycles with 3 requests pending -> 2 accepted, req_ready_o=0 afterwards, output stable; on release, in-order drain and no loss.
REQ-037 SHALL cover: op=5 from requester 1 -> data 0, err 1, id 1.
REQ-038 SHALL cover: reset asserted with both stages full -> outputs 0 asynchronously; after release, no stale response and p=0 (requester 0 wins a full contention).

Source files
------------

// File: rtl/fp_std_sched.sv
// Round-robin scheduler sharing one combinational fp_std unit among NREQ requesters
// through a two-stage {operands -> result} pipeline with valid/ready handshakes.

module fp_std #(
   parameter int unsigned WIDTH = 24
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y
);
   localparam int unsigned MW = WIDTH - 9;

   logic             sl, ss;
   logic [7:0]       el, es, sh, lz;
   logic [MW:0]      ml, ms, ms_al;
   logic [MW-1:0]    norm;
   logic [MW+1:0]    sum;
   logic             a_lt_b;
   logic [WIDTH-1:0] add_y;

   always_comb begin
      // Order operands by magnitude so the subtraction never goes negative.
      if (a[WIDTH-2:0] >= b[WIDTH-2:0]) begin
         sl = a[WIDTH-1]; el = a[WIDTH-2:MW]; ml = {|a[WIDTH-2:MW], a[MW-1:0]};
         ss = b[WIDTH-1]; es = b[WIDTH-2:MW]; ms = {|b[WIDTH-2:MW], b[MW-1:0]};
      end else begin
         sl = b[WIDTH-1]; el = b[WIDTH-2:MW]; ml = {|b[WIDTH-2:MW], b[MW-1:0]};
         ss = a[WIDTH-1]; es = a[WIDTH-2:MW]; ms = {|a[WIDTH-2:MW], a[MW-1:0]};
      end
      sh    = el - es;
      ms_al = (sh > 8'(MW)) ? '0 : ms >> sh;
      sum   = (sl == ss) ? {1'b0, ml} + {1'b0, ms_al} : {1'b0, ml} - {1'b0, ms_al};
      lz    = '0;
      for (int unsigned i = 0; i <= MW; i++) begin
         if (sum[i]) lz = 8'(MW - i);
      end
      norm  = sum[MW-1:0] << lz;
      add_y = '0;
      if (sum == '0)
         add_y = '0;
      else if (sum[MW+1])
         add_y = (el == 8'hFE) ? {sl, 8'hFF, {MW{1'b0}}} : {sl, el + 8'd1, sum[MW:1]};
      else if (el > lz)
         add_y = {sl, el - lz, norm};

      if (a[WIDTH-1] != b[WIDTH-1])
         a_lt_b = a[WIDTH-1];
      else if (!a[WIDTH-1])
         a_lt_b = a[WIDTH-2:0] < b[WIDTH-2:0];
      else
         a_lt_b = a[WIDTH-2:0] > b[WIDTH-2:0];

      case (op)
         3'd0:    y = add_y;
         3'd1:    y = a_lt_b ? b : a;
         3'd2:    y = a_lt_b ? a : b;
         default: y = '0;
      endcase
   end
endmodule

module fp_std_sched #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned NREQ  = 4,
   localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  core_clock_i,
   input  logic                  core_reset_ni,
   input  logic [NREQ-1:0]       req_valid_i,
   output logic [NREQ-1:0]       req_ready_o,
   input  logic [NREQ*WIDTH-1:0] req_a_i,
   input  logic [NREQ*WIDTH-1:0] req_b_i,
   input  logic [NREQ*3-1:0]     req_op_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [WIDTH-1:0]      rsp_data_o,
   output logic [IDW-1:0]        rsp_id_o,
   output logic                  rsp_err_o,
   output logic                  busy_o
);
   logic             s1_valid, s2_valid;
   logic [WIDTH-1:0] s1_a, s1_b, s2_data, fp_y;
   logic [2:0]       s1_op, op_sel;
   logic [IDW-1:0]   s1_id, s2_id, ptr, gnt_id;
   logic             s1_err, s2_err;
   logic             s1_adv, s2_adv, found;
   logic [NREQ-1:0]  gnt;
   int unsigned      idx;

   assign s2_adv = !s2_valid || rsp_ready_i;
   assign s1_adv = !s1_valid || s2_adv;

   // Reset is folded into the grant so ready stays low while reset is held.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid_i[idx] && s1_adv && core_reset_ni) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
         end
      end
   end

   assign op_sel = req_op_i[32'(gnt_id)*3 +: 3];

   fp_std #(.WIDTH(WIDTH)) u_fp_std (
      .a  (s1_a),
      .b  (s1_b),
      .op (s1_op),
      .y  (fp_y)
   );

   always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
      if (!core_reset_ni) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         ptr      <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s1_id    <= '0;
         s1_err   <= 1'b0;
         s2_data  <= '0;
         s2_id    <= '0;
         s2_err   <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= fp_y;
               s2_id   <= s1_id;
               s2_err  <= s1_err;
            end
         end
         if (s1_adv) begin
            s1_valid <= found;
            if (found) begin
               s1_a   <= req_a_i[32'(gnt_id)*WIDTH +: WIDTH];
               s1_b   <= req_b_i[32'(gnt_id)*WIDTH +: WIDTH];
               s1_op  <= op_sel;
               s1_id  <= gnt_id;
               s1_err <= (op_sel >= 3'd3);
               ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            end
         end
      end
   end

   assign req_ready_o = gnt;
   assign rsp_valid_o = s2_valid;
   assign rsp_data_o  = s2_data;
   assign rsp_id_o    = s2_id;
   assign rsp_err_o   = s2_err;
   assign busy_o      = s1_valid || s2_valid;
endmodule

// File: tb/tb_fp_std_sched.sv
// Self-checking bench for fp_std_sched: table of single-requester vectors plus
// round-robin, stall/drain and mid-operation reset sequences, scoreboard checked.

module tb_fp_std_sched;
   localparam int unsigned WIDTH = 24;
   localparam int unsigned NREQ  = 4;

   logic                  core_clock_i;
   logic                  core_reset_ni;
   logic [NREQ-1:0]       req_valid_i;
   logic [NREQ-1:0]       req_ready_o;
   logic [NREQ*WIDTH-1:0] req_a_i;
   logic [NREQ*WIDTH-1:0] req_b_i;
   logic [NREQ*3-1:0]     req_op_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [WIDTH-1:0]      rsp_data_o;
   logic [1:0]            rsp_id_o;
   logic                  rsp_err_o;
   logic                  busy_o;

   fp_std_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .core_clock_i  (core_clock_i),
      .core_reset_ni (core_reset_ni),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_a_i       (req_a_i),
      .req_b_i       (req_b_i),
      .req_op_i      (req_op_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_data_o    (rsp_data_o),
      .rsp_id_o      (rsp_id_o),
      .rsp_err_o     (rsp_err_o),
      .busy_o        (busy_o)
   );

   initial core_clock_i = 1'b0;
   always #5 core_clock_i = ~core_clock_i;

   typedef struct packed {
      logic [23:0] data;
      logic [1:0]  id;
      logic        err;
   } rsp_t;

   typedef struct {
      int          r;
      logic [23:0] a;
      logic [23:0] b;
      logic [2:0]  op;
      logic [23:0] y;
      logic        e;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   rsp_t        sb_q[$];
   logic [23:0] ra[NREQ], rb[NREQ], rexp[NREQ];
   logic [2:0]  rop[NREQ];
   logic        rerr[NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_a_i[i*WIDTH +: WIDTH] = ra[i];
         req_b_i[i*WIDTH +: WIDTH] = rb[i];
         req_op_i[i*3 +: 3]        = rop[i];
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge core_clock_i);
      #1;
   endtask

   task automatic set_req(input int r, input logic [23:0] a, input logic [23:0] b,
                          input logic [2:0] op, input logic [23:0] y, input logic e);
      ra[r] = a; rb[r] = b; rop[r] = op; rexp[r] = y; rerr[r] = e;
   endtask

   // Scoreboard: push on each observed accept, pop on each response handshake.
   always @(negedge core_clock_i) begin
      if (core_reset_ni) begin
         check("ready_legal", {31'd0, ($countones(req_ready_o) <= 1) &&
                                     ((req_ready_o & ~req_valid_i) == '0)}, 32'd1);
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready_o[i]) sb_q.push_back('{rexp[i], 2'(i), rerr[i]});
         end
         if (rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
               check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               rsp_t e;
               e = sb_q.pop_front();
               check("rsp_data", 32'(rsp_data_o), 32'(e.data));
               check("rsp_id",   32'(rsp_id_o),   32'(e.id));
               check("rsp_err",  32'(rsp_err_o),  32'(e.err));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t           vt[11];
      logic [NREQ-1:0] acc;
      logic [23:0]    hold;
      int             nacc;

      vt[0]  = '{0, 24'h3F8000, 24'h3F8000, 3'd0, 24'h400000, 1'b0};
      vt[1]  = '{2, 24'h3F8000, 24'h400000, 3'd1, 24'h400000, 1'b0};
      vt[2]  = '{2, 24'h3F8000, 24'h400000, 3'd2, 24'h3F8000, 1'b0};
      vt[3]  = '{1, 24'h3F8000, 24'h400000, 3'd5, 24'h000000, 1'b1};
      vt[4]  = '{3, 24'h3F8000, 24'hBF8000, 3'd0, 24'h000000, 1'b0};
      vt[5]  = '{0, 24'h400000, 24'h3F8000, 3'd0, 24'h404000, 1'b0};
      vt[6]  = '{1, 24'hC00000, 24'h3F8000, 3'd1, 24'h3F8000, 1'b0};
      vt[7]  = '{3, 24'hC00000, 24'hBF8000, 3'd2, 24'hC00000, 1'b0};
      vt[8]  = '{0, 24'h3F8000, 24'hBF0000, 3'd0, 24'h3F0000, 1'b0};
      vt[9]  = '{2, 24'h3F8000, 24'h3F8000, 3'd7, 24'h000000, 1'b1};
      vt[10] = '{1, 24'h000000, 24'h3F8000, 3'd0, 24'h3F8000, 1'b0};

      for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, '0, '0, 1'b0);
      req_valid_i   = '0;
      rsp_ready_i   = 1'b0;
      core_reset_ni = 1'b1;
      #1 core_reset_ni = 1'b0;
      req_valid_i = '1;
      #2;
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_data",  32'(rsp_data_o),  32'd0);
      check("rst_rsp_id",    32'(rsp_id_o),    32'd0);
      check("rst_rsp_err",   32'(rsp_err_o),   32'd0);
      check("rst_busy",      32'(busy_o),      32'd0);
      check("rst_ready",     32'(req_ready_o), 32'd0);
      tick(); tick();
      req_valid_i   = '0;
      core_reset_ni = 1'b1;

      // Single-requester vectors with latency check.
      for (int v = 0; v < 11; v++) begin
         tick();
         rsp_ready_i = 1'b1;
         set_req(vt[v].r, vt[v].a, vt[v].b, vt[v].op, vt[v].y, vt[v].e);
         req_valid_i = NREQ'(1) << vt[v].r;
         @(negedge core_clock_i);
         check("vec_grant", 32'(req_ready_o), 32'(NREQ'(1) << vt[v].r));
         @(posedge core_clock_i); #1;
         req_valid_i = '0;
         @(negedge core_clock_i);
         check("vec_lat_c1", 32'(rsp_valid_o), 32'd0);
         @(negedge core_clock_i);
         check("vec_lat_c2", 32'(rsp_valid_o), 32'd1);
      end
      tick(); tick();
      check("vec_drained", 32'(sb_q.size()), 32'd0);

      // Consumer stall with three requests pending.
      set_req(0, 24'h3F8000, 24'h400000, 3'd1, 24'h400000, 1'b0);
      set_req(1, 24'h3F8000, 24'h404000, 3'd1, 24'h404000, 1'b0);
      set_req(2, 24'h3F8000, 24'h3F0000, 3'd2, 24'h3F0000, 1'b0);
      rsp_ready_i = 1'b0;
      req_valid_i = 4'b0111;
      nacc = 0;
      hold = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge core_clock_i);
         acc  = req_ready_o;
         nacc = nacc + $countones(acc);
         if (c >= 2) check("stall_ready", 32'(req_ready_o), 32'd0);
         if (c == 2) hold = rsp_data_o;
         if (c == 4) begin
            check("stall_valid", 32'(rsp_valid_o), 32'd1);
            check("stall_data_stable", 32'(rsp_data_o), 32'(hold));
         end
         @(posedge core_clock_i); #1;
         req_valid_i = req_valid_i & ~acc;
      end
      check("stall_accepts", 32'(nacc), 32'd2);
      rsp_ready_i = 1'b1;
      @(negedge core_clock_i);
      check("release_grant", 32'(|req_ready_o), 32'd1);
      for (int c = 0; c < 20 && (req_valid_i != '0 || sb_q.size() != 0); c++) begin
         acc = req_ready_o;
         @(posedge core_clock_i); #1;
         req_valid_i = req_valid_i & ~acc;
         @(negedge core_clock_i);
      end
      check("stall_drained", 32'(sb_q.size()), 32'd0);
      check("stall_busy", 32'(busy_o), 32'd0);

      // Fill both stages, then reset mid-operation.
      tick();
      rsp_ready_i = 1'b0;
      req_valid_i = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         @(negedge core_clock_i);
         acc = req_ready_o;
         @(posedge core_clock_i); #1;
         req_valid_i = req_valid_i & ~acc;
      end
      check("full_busy", 32'(busy_o), 32'd1);
      check("full_valid", 32'(rsp_valid_o), 32'd1);
      req_valid_i = '1;
      #1 core_reset_ni = 1'b0;
      #1;
      check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
      check("mid_rst_data",  32'(rsp_data_o),  32'd0);
      check("mid_rst_busy",  32'(busy_o),      32'd0);
      check("mid_rst_ready", 32'(req_ready_o), 32'd0);
      sb_q.delete();
      tick(); tick();

      // Release into full contention: round-robin from requester 0 at full rate.
      set_req(0, 24'h3F8000, 24'h400000, 3'd1, 24'h400000, 1'b0);
      set_req(1, 24'h3F8000, 24'h404000, 3'd1, 24'h404000, 1'b0);
      set_req(2, 24'h3F8000, 24'h3F0000, 3'd1, 24'h3F8000, 1'b0);
      set_req(3, 24'h3F8000, 24'hBF8000, 3'd2, 24'hBF8000, 1'b0);
      rsp_ready_i   = 1'b1;
      core_reset_ni = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge core_clock_i);
         check("rr_order", 32'(req_ready_o), 32'(NREQ'(1) << (k % NREQ)));
         check(k < 2 ? "rr_no_stale" : "rr_throughput", 32'(rsp_valid_o), k < 2 ? 32'd0 : 32'd1);
         @(posedge core_clock_i); #1;
      end
      req_valid_i = '0;
      for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge core_clock_i);
      check("rr_drained", 32'(sb_q.size()), 32'd0);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
